// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding controller for a 5-stage pipeline.
// Shadows the EX/MEM/WB destination info; all outputs are combinational from that state and ID fields.
module hazard_forward_unit #(
  parameter int REG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic [REG_W-1:0] IDrs_i,
  input  logic [REG_W-1:0] IDrt_i,
  input  logic [REG_W-1:0] IDrd_i,
  input  logic             IDRegWrite_i,
  input  logic             IDMemRead_i,
  output logic [1:0]       ForwardA_o,
  output logic [1:0]       ForwardB_o,
  output logic             stall_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             bubble_o
);

  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
  localparam logic [1:0]       FWD_NONE = 2'b00;
  localparam logic [1:0]       FWD_WB   = 2'b01;
  localparam logic [1:0]       FWD_MEM  = 2'b10;

  logic [REG_W-1:0] ex_rs_r;
  logic [REG_W-1:0] ex_rt_r;
  logic [REG_W-1:0] ex_rd_r;
  logic             ex_regwrite_r;
  logic             ex_memread_r;
  logic [REG_W-1:0] mem_rd_r;
  logic             mem_regwrite_r;
  logic [REG_W-1:0] wb_rd_r;
  logic             wb_regwrite_r;

  logic             luse_s;
  logic             stall_s;
  logic             bubble_s;
  logic             write_en_s;
  logic [1:0]       fwd_a_s;
  logic [1:0]       fwd_b_s;

  // The younger producer (EX/MEM) wins; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] mem_rd,
    input logic             mem_we,
    input logic [REG_W-1:0] wb_rd,
    input logic             wb_we
  );
    logic [1:0] sel;
    if (mem_we && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

  // Load-use detection, stall/bubble/enable generation and forward selects.
  always_comb begin
    luse_s     = ex_memread_r && (ex_rd_r != REG_ZERO) &&
                 ((ex_rd_r == IDrs_i) || (ex_rd_r == IDrt_i));
    stall_s    = luse_s && !flush_i && !hold_i;
    bubble_s   = (stall_s || flush_i) && !hold_i;
    write_en_s = !stall_s && !hold_i;
    fwd_a_s    = fwd_sel(ex_rs_r, mem_rd_r, mem_regwrite_r, wb_rd_r, wb_regwrite_r);
    fwd_b_s    = fwd_sel(ex_rt_r, mem_rd_r, mem_regwrite_r, wb_rd_r, wb_regwrite_r);
  end

  // Output drive.
  always_comb begin
    ForwardA_o  = fwd_a_s;
    ForwardB_o  = fwd_b_s;
    stall_o     = stall_s;
    bubble_o    = bubble_s;
    PCWrite_o   = write_en_s;
    IFIDWrite_o = write_en_s;
  end

  // Shadow pipeline: clears on reset, frozen on hold, otherwise advances one stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_rs_r        <= REG_ZERO;
      ex_rt_r        <= REG_ZERO;
      ex_rd_r        <= REG_ZERO;
      ex_regwrite_r  <= 1'b0;
      ex_memread_r   <= 1'b0;
      mem_rd_r       <= REG_ZERO;
      mem_regwrite_r <= 1'b0;
      wb_rd_r        <= REG_ZERO;
      wb_regwrite_r  <= 1'b0;
    end else if (!hold_i) begin
      wb_rd_r        <= mem_rd_r;
      wb_regwrite_r  <= mem_regwrite_r;
      mem_rd_r       <= ex_rd_r;
      mem_regwrite_r <= ex_regwrite_r;
      if (bubble_s) begin
        ex_rs_r       <= REG_ZERO;
        ex_rt_r       <= REG_ZERO;
        ex_rd_r       <= REG_ZERO;
        ex_regwrite_r <= 1'b0;
        ex_memread_r  <= 1'b0;
      end else begin
        ex_rs_r       <= IDrs_i;
        ex_rt_r       <= IDrt_i;
        ex_rd_r       <= IDrd_i;
        ex_regwrite_r <= IDRegWrite_i;
        ex_memread_r  <= IDMemRead_i;
      end
    end else begin
      ex_rs_r        <= ex_rs_r;
      ex_rt_r        <= ex_rt_r;
      ex_rd_r        <= ex_rd_r;
      ex_regwrite_r  <= ex_regwrite_r;
      ex_memread_r   <= ex_memread_r;
      mem_rd_r       <= mem_rd_r;
      mem_regwrite_r <= mem_regwrite_r;
      wb_rd_r        <= wb_rd_r;
      wb_regwrite_r  <= wb_regwrite_r;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios plus randomized
// traffic compared against an instruction-level pipeline model.
module tb_hazard_forward_unit;

  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             in_rst, in_hold, in_flush;
  logic [REG_W-1:0] in_rs, in_rt, in_rd;
  logic             in_rw, in_mr;
  logic [1:0]       fa, fb;
  logic             stall, pcw, ifidw, bubble;

  int checks = 0;
  int errors = 0;

  hazard_forward_unit #(.REG_W(REG_W)) dut (
    .clk_i(clk), .rst_i(in_rst), .hold_i(in_hold), .flush_i(in_flush),
    .IDrs_i(in_rs), .IDrt_i(in_rt), .IDrd_i(in_rd),
    .IDRegWrite_i(in_rw), .IDMemRead_i(in_mr),
    .ForwardA_o(fa), .ForwardB_o(fb), .stall_o(stall),
    .PCWrite_o(pcw), .IFIDWrite_o(ifidw), .bubble_o(bubble)
  );

  always #5 clk = ~clk;

  // Instruction-level model: pipe[0] is in EX, pipe[1] in MEM, pipe[2] in WB.
  typedef struct packed {
    logic [REG_W-1:0] rs, rt, rd;
    logic             rw, mr;
  } instr_t;

  instr_t     pipe [0:2];
  logic [1:0] m_fa, m_fb;
  logic       m_stall, m_bubble, m_we;

  // Nearest older instruction that writes src supplies the operand.
  function automatic logic [1:0] m_fwd(input logic [REG_W-1:0] src);
    for (int k = 1; k <= 2; k++) begin
      if (pipe[k].rw && pipe[k].rd != 5'd0 && pipe[k].rd == src)
        return (k == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic void model_eval();
    logic luse;
    luse     = pipe[0].mr && pipe[0].rd != 5'd0 && (pipe[0].rd == in_rs || pipe[0].rd == in_rt);
    m_stall  = luse && !in_flush && !in_hold;
    m_bubble = (m_stall || in_flush) && !in_hold;
    m_we     = !m_stall && !in_hold;
    m_fa     = m_fwd(pipe[0].rs);
    m_fb     = m_fwd(pipe[0].rt);
  endfunction

  function automatic void model_advance();
    instr_t id;
    id = '{rs: in_rs, rt: in_rt, rd: in_rd, rw: in_rw, mr: in_mr};
    if (in_rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = '0;
    end else if (!in_hold) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = m_bubble ? instr_t'('0) : id;
    end
  endfunction

  // One cycle: the edge consumes the previous inputs, then new inputs are applied and settle.
  task automatic step(input logic [REG_W-1:0] rs, rt, rd, input logic rw, mr, fl, hd, rst);
    @(posedge clk);
    model_advance();
    #1;
    in_rs = rs; in_rt = rt; in_rd = rd; in_rw = rw; in_mr = mr;
    in_flush = fl; in_hold = hd; in_rst = rst;
    #1;
    model_eval();
  endtask

  task automatic nop();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, (i < 2) ? 1'b1 : 1'b0);
      if (i == 0) continue;
      checks++;
      if ({fa, fb, stall, bubble, pcw, ifidw} !== 8'b0000_0011) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got fa=%b fb=%b st=%b bb=%b pcw=%b ifid=%b, want 00 00 0 0 1 1",
                 i, fa, fb, stall, bubble, pcw, ifidw);
      end
    end
  endtask

  task automatic test_alu_chain();
    step(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // add $3
    step(5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // sub rs=3
    step(5'd0, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // or rt=3
    checks++;
    if (fa !== 2'b10) begin errors++; $display("FAIL alu_sub_fwdA: got %b want 10", fa); end
    step(5'd3, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // and rs=3
    checks++;
    if (fb !== 2'b01) begin errors++; $display("FAIL alu_or_fwdB: got %b want 01", fb); end
    nop();
    checks++;
    if (fa !== 2'b00) begin errors++; $display("FAIL alu_and_fwdA: got %b want 00", fa); end
    nop(); nop(); nop();
  endtask

  task automatic test_priority();
    step(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nop();
    checks++;
    if (fa !== 2'b10) begin errors++; $display("FAIL priority_fwdA: got %b want 10", fa); end
    nop(); nop(); nop();
  endtask

  task automatic test_zero();
    step(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // load to $0
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // reader of $0
    checks++;
    if ({stall, pcw} !== 2'b01) begin
      errors++; $display("FAIL zero_no_stall: got st=%b pcw=%b want 0 1", stall, pcw);
    end
    nop();
    checks++;
    if (fa !== 2'b00) begin errors++; $display("FAIL zero_fwdA: got %b want 00", fa); end
    nop(); nop();
  endtask

  task automatic test_load_use();
    step(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // lw $4
    step(5'd1, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // add rt=4
    checks++;
    if ({stall, bubble, pcw, ifidw} !== 4'b1100) begin
      errors++; $display("FAIL loaduse_stall: got st=%b bb=%b pcw=%b ifid=%b want 1 1 0 0",
                         stall, bubble, pcw, ifidw);
    end
    step(5'd1, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // add held in ID
    checks++;
    if ({stall, bubble, pcw} !== 3'b001) begin
      errors++; $display("FAIL loaduse_release: got st=%b bb=%b pcw=%b want 0 0 1", stall, bubble, pcw);
    end
    nop();
    checks++;
    if (fb !== 2'b01) begin errors++; $display("FAIL loaduse_fwdB: got %b want 01", fb); end
    nop(); nop(); nop();
  endtask

  task automatic test_flush();
    step(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd0, 5'd4, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({stall, bubble, pcw, ifidw} !== 4'b0111) begin
      errors++; $display("FAIL flush_luse: got st=%b bb=%b pcw=%b ifid=%b want 0 1 1 1",
                         stall, bubble, pcw, ifidw);
    end
    nop();
    checks++;
    if (fb !== 2'b00) begin errors++; $display("FAIL flush_squash_fwdB: got %b want 00", fb); end
    nop(); nop(); nop();
  endtask

  task automatic test_hold();
    step(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, (i < 3) ? 1'b1 : 1'b0, 1'b0);
      checks++;
      if (fa !== 2'b10) begin errors++; $display("FAIL hold_fwdA cyc%0d: got %b want 10", i, fa); end
      if (i < 3) begin
        checks++;
        if ({stall, bubble, pcw, ifidw} !== 4'b0000) begin
          errors++; $display("FAIL hold_ctrl cyc%0d: got st=%b bb=%b pcw=%b ifid=%b want 0 0 0 0",
                             i, stall, bubble, pcw, ifidw);
        end
      end
    end
    nop();
    checks++;
    if (fa !== 2'b00) begin errors++; $display("FAIL hold_resume_fwdA: got %b want 00", fa); end
    nop(); nop();
  endtask

  task automatic test_reset_during_hold();
    step(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({fa, fb} !== 4'b1010) begin
      errors++; $display("FAIL rsthold_before: got fa=%b fb=%b want 10 10", fa, fb);
    end
    nop();
    checks++;
    if ({fa, fb, stall, pcw} !== 6'b0000_01) begin
      errors++; $display("FAIL rsthold_after: got fa=%b fb=%b st=%b pcw=%b want 00 00 0 1",
                         fa, fb, stall, pcw);
    end
  endtask

  task automatic test_random();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 49) == 0));
      checks++;
      if ({fa, fb, stall, bubble, pcw, ifidw} !== {m_fa, m_fb, m_stall, m_bubble, m_we, m_we}) begin
        errors++;
        $display("FAIL random cyc%0d: got fa=%b fb=%b st=%b bb=%b pcw=%b ifid=%b want %b %b %b %b %b %b",
                 i, fa, fb, stall, bubble, pcw, ifidw, m_fa, m_fb, m_stall, m_bubble, m_we, m_we);
      end
    end
  endtask

  initial begin
    in_rst = 1'b1; in_hold = 1'b0; in_flush = 1'b0;
    in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_rw = 1'b0; in_mr = 1'b0;
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    model_eval();
    test_reset();
    test_alu_chain();
    test_priority();
    test_zero();
    test_load_use();
    test_flush();
    test_hold();
    test_reset_during_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
